// File: rtl/mccpu_mem_pkg.sv
// Shared constants for the mccpu memory/I-O subsystem.
//   IO_NIB_DEFAULT : default madr[31:28] value selecting the I/O page
//   OFS_*          : I/O register word offsets, compared against madr[7:2]
//   ST_*           : STATUS register bit positions
package mccpu_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFS_W  = 6;

  localparam logic [3:0] IO_NIB_DEFAULT = 4'hF;

  // Word offsets (byte offset >> 2)
  localparam logic [OFS_W-1:0] OFS_CYCLE  = 6'h00;  // 0x00
  localparam logic [OFS_W-1:0] OFS_LOAD   = 6'h01;  // 0x04
  localparam logic [OFS_W-1:0] OFS_CNT    = 6'h02;  // 0x08
  localparam logic [OFS_W-1:0] OFS_STATUS = 6'h03;  // 0x0C
  localparam logic [OFS_W-1:0] OFS_OUT    = 6'h11;  // 0x44

  localparam int unsigned ST_EXPIRED = 0;
  localparam int unsigned ST_ERR     = 1;

endpackage

// File: rtl/mccpu_io_timer.sv
// Auto-reload down-counter behind the LOAD/CNT registers.
//   clock, resetn : clock and async active-low reset
//   load_we       : LOAD register write strobe (also reloads CNT)
//   load_data     : value written to LOAD and CNT
//   clr_expired   : write-1-to-clear request for the expired flag
//   cnt, load     : current counter and reload values
//   expired       : sticky flag, set when CNT reloads from 1
module mccpu_io_timer
  import mccpu_mem_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              load_we,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clr_expired,
  output logic [DATA_W-1:0] cnt,
  output logic [DATA_W-1:0] load,
  output logic              expired
);

  // A LOAD write pre-empts the countdown, so no expiry that cycle.
  logic expire_c;
  assign expire_c = !load_we && (cnt == DATA_W'(1));

  // Counter / reload register; CNT==0 means stopped.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      load <= '0;
    end else if (load_we) begin
      load <= load_data;
      cnt  <= load_data;
    end else if (cnt > DATA_W'(1)) begin
      cnt <= cnt - DATA_W'(1);
    end else if (cnt == DATA_W'(1)) begin
      cnt <= load;
    end
  end

  // Sticky flag: a set in the same cycle as a clear wins.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      expired <= 1'b0;
    end else begin
      expired <= expire_c || (expired && !clr_expired);
    end
  end

endmodule

// File: rtl/mccpu_mem_bus.sv
// Memory and I/O subsystem behind the mccpu memory port.
//   clock, resetn        : clock and async active-low reset
//   madr, tomem, wmem    : CPU byte address, write data, write strobe
//   frommem              : registered read data (1-cycle latency)
//   prog_we/addr/data    : program-load port into RAM (wins over CPU writes)
//   out_port             : OUT register
//   timer_irq, bus_err   : STATUS.expired and STATUS.err
module mccpu_mem_bus
  import mccpu_mem_pkg::*;
#(
  parameter int unsigned RAM_AW = 5,
  parameter logic [3:0]  IO_NIB = IO_NIB_DEFAULT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [31:0]       madr,
  input  logic [31:0]       tomem,
  input  logic              wmem,
  output logic [31:0]       frommem,
  input  logic              prog_we,
  input  logic [RAM_AW-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic [31:0]       out_port,
  output logic              timer_irq,
  output logic              bus_err
);

  localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;

  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [DATA_W-1:0] cycle;
  logic              err;
  logic [DATA_W-1:0] t_cnt;
  logic [DATA_W-1:0] t_load;
  logic              t_expired;

  logic              is_io_c;
  logic              is_ram_c;
  logic [OFS_W-1:0]  ofs_c;
  logic [RAM_AW-1:0] ram_idx_c;
  logic              io_ofs_ok_c;
  logic              err_set_c;
  logic              sts_we_c;
  logic              load_we_c;
  logic              out_we_c;
  logic              ram_we_c;
  logic [DATA_W-1:0] status_c;
  logic [DATA_W-1:0] rd_data_c;

  // Byte-lane bits are never used for addressing.
  logic unused_adr;
  assign unused_adr = ^madr[1:0];

  // Address decode; the I/O page takes precedence.
  always_comb begin
    is_io_c     = (madr[31:28] == IO_NIB);
    is_ram_c    = !is_io_c && (madr[31:RAM_AW+2] == '0);
    ofs_c       = madr[7:2];
    ram_idx_c   = madr[RAM_AW+1:2];
    io_ofs_ok_c = (ofs_c == OFS_CYCLE) || (ofs_c == OFS_LOAD) ||
                  (ofs_c == OFS_CNT) || (ofs_c == OFS_STATUS) ||
                  (ofs_c == OFS_OUT);
    load_we_c   = wmem && is_io_c && (ofs_c == OFS_LOAD);
    sts_we_c    = wmem && is_io_c && (ofs_c == OFS_STATUS);
    out_we_c    = wmem && is_io_c && (ofs_c == OFS_OUT);
    ram_we_c    = wmem && is_ram_c;
    err_set_c   = wmem && ((!is_io_c && !is_ram_c) || (is_io_c && !io_ofs_ok_c));
  end

  // STATUS register image.
  always_comb begin
    status_c             = '0;
    status_c[ST_EXPIRED] = t_expired;
    status_c[ST_ERR]     = err;
  end

  // Read mux; RAM read sees pre-edge contents, giving old-data on collision.
  always_comb begin
    rd_data_c = '0;
    if (is_ram_c) begin
      rd_data_c = mem[ram_idx_c];
    end else if (is_io_c) begin
      case (ofs_c)
        OFS_CYCLE:  rd_data_c = cycle;
        OFS_LOAD:   rd_data_c = t_load;
        OFS_CNT:    rd_data_c = t_cnt;
        OFS_STATUS: rd_data_c = status_c;
        OFS_OUT:    rd_data_c = out_port;
        default:    rd_data_c = '0;
      endcase
    end
  end

  // Unified RAM, no reset; the program port wins a same-cycle collision.
  always_ff @(posedge clock) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end else if (ram_we_c) begin
      mem[ram_idx_c] <= tomem;
    end
  end

  // Read data, cycle counter, OUT register and sticky err.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      frommem  <= '0;
      cycle    <= '0;
      out_port <= '0;
      err      <= 1'b0;
    end else begin
      frommem <= rd_data_c;
      cycle   <= cycle + DATA_W'(1);
      if (out_we_c) begin
        out_port <= tomem;
      end
      err <= err_set_c || (err && !(sts_we_c && tomem[ST_ERR]));
    end
  end

  mccpu_io_timer u_timer (
    .clock       (clock),
    .resetn      (resetn),
    .load_we     (load_we_c),
    .load_data   (tomem),
    .clr_expired (sts_we_c && tomem[ST_EXPIRED]),
    .cnt         (t_cnt),
    .load        (t_load),
    .expired     (t_expired)
  );

  assign timer_irq = t_expired;
  assign bus_err   = err;

endmodule

// File: tb/tb_mccpu_mem_bus.sv
module tb_mccpu_mem_bus;

  logic        clock;
  logic        resetn;
  logic [31:0] madr;
  logic [31:0] tomem;
  logic        wmem;
  logic [31:0] frommem;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] out_port;
  logic        timer_irq;
  logic        bus_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pwe;
    logic [4:0]  paddr;
    logic [31:0] pdata;
    logic        chk;
    logic [31:0] exp_rd;
    logic [31:0] exp_out;
    logic        exp_irq;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  mccpu_mem_bus #(.RAM_AW(5), .IO_NIB(4'hF)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .madr      (madr),
    .tomem     (tomem),
    .wmem      (wmem),
    .frommem   (frommem),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .out_port  (out_port),
    .timer_irq (timer_irq),
    .bus_err   (bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic pwe, input logic [4:0] paddr, input logic [31:0] pdata,
                              input logic chk, input logic [31:0] exp_rd, input logic [31:0] exp_out,
                              input logic exp_irq, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata;
    v.pwe = pwe; v.paddr = paddr; v.pdata = pdata;
    v.chk = chk; v.exp_rd = exp_rd; v.exp_out = exp_out;
    v.exp_irq = exp_irq; v.exp_err = exp_err;
    return v;
  endfunction

  // Called at a falling edge: drive, take one rising edge, compare, return at next falling edge.
  task automatic apply(input string nm, input vec_t v);
    logic [31:0] e;
    wmem      = v.we;
    madr      = v.addr;
    tomem     = v.wdata;
    prog_we   = v.pwe;
    prog_addr = v.paddr;
    prog_data = v.pdata;
    if (v.chk) exp_q.push_back(v.exp_rd);
    @(posedge clock);
    #1;
    if (v.chk) begin
      e = exp_q.pop_front();
      check({nm, " frommem"}, frommem, e);
    end
    check({nm, " out_port"}, out_port, v.exp_out);
    check({nm, " timer_irq"}, 32'(timer_irq), 32'(v.exp_irq));
    check({nm, " bus_err"}, 32'(bus_err), 32'(v.exp_err));
    @(negedge clock);
  endtask

  vec_t v;
  logic [31:0] exp_cnt [6];
  logic        exp_irq [6];

  initial begin
    resetn = 1'b0; wmem = 1'b0; madr = '0; tomem = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;

    vecs[0]  = mk(0, 32'hF000_0000, 0,     0, 0, 0,            1, 32'h0,         32'h0, 0, 0);
    vecs[1]  = mk(0, 32'h0000_0000, 0,     1, 1, 32'h3C08_F000, 0, 32'h0,        32'h0, 0, 0);
    vecs[2]  = mk(0, 32'h0000_0004, 0,     0, 0, 0,            1, 32'h3C08_F000, 32'h0, 0, 0);
    vecs[3]  = mk(1, 32'h0000_0004, 32'h1234, 1, 1, 32'hAAAA,  0, 32'h0,         32'h0, 0, 0);
    vecs[4]  = mk(0, 32'h0000_0004, 0,     0, 0, 0,            1, 32'hAAAA,      32'h0, 0, 0);
    vecs[5]  = mk(1, 32'hF000_0046, 32'hF, 0, 0, 0,            0, 32'h0,         32'hF, 0, 0);
    vecs[6]  = mk(0, 32'hF000_0044, 0,     0, 0, 0,            1, 32'hF,         32'hF, 0, 0);
    vecs[7]  = mk(1, 32'h8000_0000, 32'hDEAD, 0, 0, 0,         0, 32'h0,         32'hF, 0, 1);
    vecs[8]  = mk(0, 32'h8000_0000, 0,     0, 0, 0,            1, 32'h0,         32'hF, 0, 1);
    vecs[9]  = mk(0, 32'h0000_0004, 0,     0, 0, 0,            1, 32'hAAAA,      32'hF, 0, 1);
    vecs[10] = mk(1, 32'hF000_000C, 32'h2, 0, 0, 0,            0, 32'h0,         32'hF, 0, 0);
    vecs[11] = mk(1, 32'hF000_0020, 32'h55, 0, 0, 0,           0, 32'h0,         32'hF, 0, 1);
    vecs[12] = mk(0, 32'hF000_000C, 0,     0, 0, 0,            1, 32'h2,         32'hF, 0, 1);
    vecs[13] = mk(1, 32'hF000_000C, 32'h2, 0, 0, 0,            0, 32'h0,         32'hF, 0, 0);

    exp_cnt = '{32'd3, 32'd2, 32'd1, 32'd3, 32'd2, 32'd1};
    exp_irq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset held for two clocks
    repeat (2) @(posedge clock);
    #1;
    check("rst frommem", frommem, 32'h0);
    check("rst out_port", out_port, 32'h0);
    check("rst timer_irq", 32'(timer_irq), 32'h0);
    check("rst bus_err", 32'(bus_err), 32'h0);
    @(negedge clock);
    resetn = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Timer: LOAD=3, then watch CNT count 3,2,1 and reload
    apply("tmr load", mk(1, 32'hF000_0004, 32'd3, 0, 0, 0, 0, 0, 32'hF, 0, 0));
    for (int k = 0; k < 6; k++) begin
      apply($sformatf("tmr cnt%0d", k),
            mk(0, 32'hF000_0008, 0, 0, 0, 0, 1, exp_cnt[k], 32'hF, exp_irq[k], 0));
    end
    apply("tmr clr", mk(1, 32'hF000_000C, 32'h1, 0, 0, 0, 0, 0, 32'hF, 0, 0));
    apply("tmr cnt2b", mk(0, 32'hF000_0008, 0, 0, 0, 0, 1, 32'd2, 32'hF, 0, 0));
    apply("tmr clr_vs_set", mk(1, 32'hF000_000C, 32'h1, 0, 0, 0, 0, 0, 32'hF, 1, 0));
    apply("tmr cnt3b", mk(0, 32'hF000_0008, 0, 0, 0, 0, 1, 32'd3, 32'hF, 1, 0));
    apply("tmr status", mk(0, 32'hF000_000C, 0, 0, 0, 0, 1, 32'h1, 32'hF, 1, 0));

    // Reset mid-count: LOAD=5 sets CNT=5, frommem shows old LOAD (3)
    apply("mid load5", mk(1, 32'hF000_0004, 32'd5, 0, 0, 0, 1, 32'd3, 32'hF, 1, 0));
    wmem = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    check("async frommem", frommem, 32'h0);
    check("async out_port", out_port, 32'h0);
    check("async timer_irq", 32'(timer_irq), 32'h0);
    check("async bus_err", 32'(bus_err), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    apply("post cycle", mk(0, 32'hF000_0000, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0));
    apply("post cnt", mk(0, 32'hF000_0008, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0));
    apply("post ram", mk(0, 32'h0000_0004, 0, 0, 0, 0, 1, 32'hAAAA, 32'h0, 0, 0));

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: got %0d left required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
